// File: rtl/data_memory_if.sv
// data_memory_if: request/response bus of data_memory_sync.
interface data_memory_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  memwrite;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  busy;
  modport master (
    output req_valid, memwrite, address, write_data,
    input  req_ready, resp_valid, data_out, busy
  );
  modport slave (
    input  req_valid, memwrite, address, write_data,
    output req_ready, resp_valid, data_out, busy
  );
endinterface

// File: rtl/data_memory_sync.sv
// data_memory_sync: pipelined sync RAM; DATA_MEMORY_INIT_EN adds a zeroing sweep after reset.
module data_memory_sync #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input logic          clk,
  input logic          reset,
  data_memory_if.slave bus
);
`ifdef DATA_MEMORY_INIT_EN
  typedef enum logic [1:0] {S_IDLE, S_INIT, S_READY} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_READY} state_t;
`endif
  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic                  accept, rd_accept, rd_v, resp_v;
  logic [DATA_WIDTH-1:0] rd_d, resp_d;
  assign bus.req_ready = state == S_READY && !reset;
  assign accept        = bus.req_valid && bus.req_ready;
  assign rd_accept     = accept && !bus.memwrite;
  always_ff @(posedge clk) state <= reset ? S_IDLE : state_nxt;
`ifdef DATA_MEMORY_INIT_EN
  localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'((1 << ADDR_WIDTH) - 1);
  logic [ADDR_WIDTH:0] cnt;
  always_comb state_nxt = state == S_IDLE ? S_INIT : (state == S_INIT && cnt != LAST) ? S_INIT : S_READY;
  always_ff @(posedge clk) cnt <= (reset || state != S_INIT) ? '0 : cnt + (ADDR_WIDTH+1)'(1);
  assign bus.busy = state == S_INIT && !reset;
  always_ff @(posedge clk)
    if (state == S_INIT && !reset) mem[cnt[ADDR_WIDTH-1:0]] <= '0;
    else if (accept && bus.memwrite) mem[bus.address] <= bus.write_data;
`else
  always_comb state_nxt = S_READY;
  assign bus.busy = 1'b0;
  always_ff @(posedge clk)
    if (accept && bus.memwrite) mem[bus.address] <= bus.write_data;
`endif
  always_ff @(posedge clk)
    if (reset) begin
      rd_v <= 1'b0;
      rd_d <= '0;
    end else begin
      rd_v <= rd_accept;
      if (rd_accept) rd_d <= mem[bus.address];
    end
  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  v2;
      logic [DATA_WIDTH-1:0] d2;
      always_ff @(posedge clk)
        if (reset) begin
          v2 <= 1'b0;
          d2 <= '0;
        end else begin
          v2 <= rd_v;
          if (rd_v) d2 <= rd_d;
        end
      assign resp_v = v2;
      assign resp_d = d2;
    end else begin : g_lat1
      assign resp_v = rd_v;
      assign resp_d = rd_d;
    end
  endgenerate
  // Outputs are forced quiet combinationally so in-flight reads vanish the moment reset rises.
  assign bus.resp_valid = resp_v && !reset;
  assign bus.data_out   = reset ? '0 : resp_d;
endmodule

// File: tb/tb_data_memory_sync.sv
// tb_data_memory_sync: scoreboard bench driving a latency-1 and a latency-2 instance in lockstep.
module tb_data_memory_sync;
`ifdef DATA_MEMORY_INIT_EN
  localparam int INIT_CYC = 256;
`else
  localparam int INIT_CYC = 0;
`endif
  localparam bit IE = INIT_CYC != 0;
  typedef struct {int due; logic [7:0] data;} exp_t;
  logic clk = 1'b0, reset = 1'b1, req_valid = 1'b0, memwrite = 1'b0;
  logic [7:0] address = '0, write_data = '0;
  int cyc = 0, n_chk = 0, n_err = 0;
  exp_t q1[$], q2[$];
  data_memory_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) i1 ();
  data_memory_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) i2 ();
  assign i1.req_valid = req_valid;
  assign i1.memwrite = memwrite;
  assign i1.address = address;
  assign i1.write_data = write_data;
  assign i2.req_valid = req_valid;
  assign i2.memwrite = memwrite;
  assign i2.address = address;
  assign i2.write_data = write_data;
  data_memory_sync #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .READ_LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(i1.slave));
  data_memory_sync #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .READ_LATENCY(2)) dut2 (.clk(clk), .reset(reset), .bus(i2.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  always @(negedge clk)
    if (q1.size() != 0 && q1[0].due == cyc) begin
      chk("lat1_valid", i1.resp_valid, 1);
      chk("lat1_data", i1.data_out, q1[0].data);
      void'(q1.pop_front());
    end else if (i1.resp_valid) chk("lat1_spurious", i1.resp_valid, 0);
  always @(negedge clk)
    if (q2.size() != 0 && q2[0].due == cyc) begin
      chk("lat2_valid", i2.resp_valid, 1);
      chk("lat2_data", i2.data_out, q2[0].data);
      void'(q2.pop_front());
    end else if (i2.resp_valid) chk("lat2_spurious", i2.resp_valid, 0);
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    req_valid = 1'b1; memwrite = 1'b1; address = a; write_data = d;
    tick;
    req_valid = 1'b0;
  endtask
  task automatic rd(input logic [7:0] a, input logic [7:0] exp);
    req_valid = 1'b1; memwrite = 1'b0; address = a;
    tick;
    q1.push_back('{cyc, exp});
    q2.push_back('{cyc + 1, exp});
    req_valid = 1'b0;
  endtask
  // A write attempt is driven while reset is high; it must never land.
  task automatic do_reset(input bit hold);
    int n = 0, it = 0;
    reset = 1'b1;
    q1.delete();
    q2.delete();
    req_valid = 1'b1; memwrite = 1'b1; address = 8'h05; write_data = 8'h99;
    tick;
    chk("rst_ready1", i1.req_ready, 0);
    chk("rst_ready2", i2.req_ready, 0);
    chk("rst_resp1", i1.resp_valid, 0);
    chk("rst_resp2", i2.resp_valid, 0);
    chk("rst_data1", i1.data_out, 0);
    chk("rst_data2", i2.data_out, 0);
    chk("rst_busy", i1.busy, 0);
    tick;
    req_valid = hold; address = 8'h10; write_data = 8'hAA;
    reset = 1'b0;
    while (!i1.req_ready && it < 2000) begin
      if (i1.busy) n++;
      it++;
      tick;
    end
    chk("init_busy_cycles", n, INIT_CYC);
    chk("ready_latency", it, INIT_CYC + 1);
    chk("ready2", i2.req_ready, 1);
    chk("busy_after_init", i1.busy, 0);
    if (hold) tick;
    req_valid = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tick;
    do_reset(1);
    rd(8'h10, 8'hAA);
`ifdef DATA_MEMORY_INIT_EN
    rd(8'h1C, 8'h00);
`endif
    wr(8'h24, 8'hE6);
    rd(8'h24, 8'hE6);
    repeat (3) tick;
    chk("hold1", i1.data_out, 8'hE6);
    chk("hold2", i2.data_out, 8'hE6);
    wr(8'h35, 8'h55);
    wr(8'hFE, 8'h0F);
    wr(8'hFF, 8'h00);
    rd(8'h35, 8'h55);
    rd(8'hFE, 8'h0F);
    rd(8'hFF, 8'h00);
    repeat (3) tick;
    wr(8'h05, 8'h3C);
    do_reset(0);
    rd(8'h05, IE ? 8'h00 : 8'h3C);
    rd(8'h24, IE ? 8'h00 : 8'hE6);
    repeat (3) tick;
    rd(8'h35, IE ? 8'h00 : 8'h55);
    rd(8'hFE, IE ? 8'h00 : 8'h0F);
    do_reset(0);
    rd(8'h35, IE ? 8'h00 : 8'h55);
    repeat (4) tick;
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/data_memory_sync.md
DATA_MEMORY_SYNC -- requirements
Module: data_memory_sync

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width in bits of each memory word.
REQ-002 Parameter ADDR_WIDTH, default 8: address width; depth = 2**ADDR_WIDTH words.
REQ-003 Parameter READ_LATENCY, default 1: cycles from read accept to resp_valid; legal values 1 or 2 only.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous active-high reset, sampled on clk rising edge.
REQ-007 req_valid  input  1  request present this cycle.
REQ-008 req_ready  output  1  block can accept a request this cycle.
REQ-009 memwrite  input  1  1 = write request, 0 = read request; qualified by req_valid.
REQ-010 address  input  ADDR_WIDTH  word address of the request.
REQ-011 write_data  input  DATA_WIDTH  data for write requests; ignored on reads.
REQ-012 resp_valid  output  1  data_out holds read data this cycle.
REQ-013 data_out  output  DATA_WIDTH  read data; held at last value when resp_valid=0.
REQ-014 busy  output  1  high while the init sweep is running.

Function
REQ-015 Accept occurs when req_valid && req_ready at a rising clk edge; exactly one request per accepting edge.
REQ-016 Write accept SHALL update mem[address] at that edge; no response pulse is generated for writes.
REQ-017 Read accept SHALL produce resp_valid=1 for exactly one cycle, READ_LATENCY cycles after the accepting edge, with data_out = mem[address].
REQ-018 Reads SHALL be fully pipelined: back-to-back reads each cycle yield back-to-back resp_valid pulses, in order.
REQ-019 Write-then-read to the same address on consecutive accepts SHALL return the newly written data (no stale read).
REQ-020 There is no response backpressure; consumers must take data_out on the resp_valid cycle.
REQ-021 State machine: INIT (sweep running, req_ready=0, busy=1) and READY (req_ready=1, busy=0).
REQ-022 INIT: a counter of ADDR_WIDTH+1 bits writes 0 to mem[counter] each cycle, starting at 0; after writing address 2**ADDR_WIDTH-1 it transitions to READY on the next edge.
REQ-023 The counter SHALL NOT wrap; the sweep takes exactly 2**ADDR_WIDTH cycles.
REQ-024 Requests presented during INIT are not accepted and have no effect.
REQ-025 Address arithmetic SHALL use the full ADDR_WIDTH; all addresses are valid and no out-of-range case exists.

Reset
REQ-026 While reset=1: req_ready=0, resp_valid=0, data_out=0, busy=0, read pipeline cleared, and the state machine SHALL be held in its entry state.
REQ-027 Reset asserted mid-operation SHALL discard in-flight reads; their resp_valid pulses never appear.
REQ-028 Reset asserted during INIT SHALL restart the sweep from address 0 after release.
REQ-029 Memory array contents are changed only by the INIT sweep, never directly by reset.

Configuration
REQ-030 Macro DATA_MEMORY_INIT_EN: when defined, the first edge after reset deasserts enters INIT and runs the zero sweep of REQ-022.
REQ-031 Without DATA_MEMORY_INIT_EN: no INIT state; the block enters READY on the first edge after reset deasserts; memory retains prior contents; busy is tied to 0.

Verification
REQ-032 Default parameters, INIT_EN defined: release reset -> busy=1 and req_ready=0 for 256 cycles, then req_ready=1; a read of 0x1C returns 0x00.
REQ-033 Write 0x24<=0xE6, next cycle read 0x24 (READ_LATENCY=1) -> one cycle after the read accept, resp_valid=1 and data_out=0xE6.
REQ-034 READ_LATENCY=2: write 0x35<=0x55 and 0xFE<=0x0F, then back-to-back reads of 0x35, 0xFE, 0xFF -> resp_valid high for three consecutive cycles starting 2 cycles after the first read, with data 0x55, 0x0F, 0x00.
REQ-035 Issue two reads, then assert reset on the next edge -> no resp_valid pulses; after release, all outputs are at their reset values and the INIT sweep restarts at address 0.
REQ-036 req_valid=1 with memwrite=1, address 0x10, data 0xAA held throughout INIT -> no write occurs during INIT; the first READY edge accepts it; a subsequent read of 0x10 returns 0xAA.
REQ-037 INIT_EN undefined: preload mem[0x05]=0x3C, pulse reset -> req_ready=1 the cycle after release; a read of 0x05 returns 0x3C.
